tile_stage_scheduler: RTL
=========================

# tile_stage_scheduler

Sequences one processing lane through the per-tile stage chain stage2 → stage3 → stage5 → stage6. It issues start pulses, waits on each stage's `finished`, and drives the VPE `mode` ownership bits for the lane's seven VPE slots. It also presents the current tile index for SRAM address generation. One instance per lane sits beside the lane's SRAM controllers in the memory controller, and a per-stage watchdog catches a stage that never finishes.

## Interface
- `CNT_W`, default 16: width of the tile count and tile index.
- `PIPE`, default 7: number of VPE slots per lane.
- `S3_LAT`, default 1: fixed stage3 latency in cycles; must be ≥1.
- `TIMEOUT`, default 1024: cycles a stage may run before it is declared hung; must be ≥2.
- `CLK_i` in, 1: clock. One clock domain.
- `RST_i` in, 1: reset. Synchronous and active-high.
- `start_i` in, 1: job start request. Sampled in IDLE, DONE and ERR.
- `tile_cnt_i` in, `CNT_W`: number of tiles in the job. Latched when the start is accepted.
- `stall_i` in, 1: freezes the scheduler.
- `finished_i` in, 3: stage done flags. Bit 0 is stage2, bit 1 is stage5, bit 2 is stage6.
- `stage_start_o` out, 4: one-cycle start pulses. Bit 0 stage2, bit 1 stage3, bit 2 stage5, bit 3 stage6.
- `vpe_mode_o` out, `PIPE`: VPE slot ownership / mode enables.
- `tile_idx_o` out, `CNT_W`: index of the tile in flight.
- `busy_o` out, 1: a job is in progress.
- `done_o` out, 1: one-cycle pulse when the job completes.
- `err_o` out, 1: sticky watchdog error.
- `err_stage_o` out, 2: code of the stage that timed out. 0 = stage2, 2 = stage5, 3 = stage6.

## Operation
- **States:** IDLE, S2_RUN, S3_WAIT, S5_RUN, S6_RUN, NEXT, DONE, ERR.
- **Reset state:** IDLE.
- **Reset values:** all outputs 0. Tile counter, watchdog counter and the latched count are all 0.
- **IDLE + `start_i`:**
  - latch `tile_cnt_i` and clear `tile_idx_o`;
  - if the count is 0, go to DONE and issue no stage starts;
  - otherwise go to S2_RUN.
- **Start while busy:** `start_i` in any RUN/WAIT/NEXT state is ignored.
- **Stage start pulses:** the pulse fires on the first non-stalled cycle of each state visit.
  - S2_RUN pulses bit 0.
  - S3_WAIT pulses bit 1.
  - S5_RUN pulses bit 2.
  - S6_RUN pulses bit 3.
- **S2_RUN, S5_RUN, S6_RUN:**
  - wait for the matching `finished_i` bit, then go to S3_WAIT, S6_RUN or NEXT respectively;
  - `finished_i` is ignored in the pulse cycle;
  - `finished_i` is ignored for stages that are not active.
- **S3_WAIT:** stays exactly `S3_LAT` non-stalled cycles, then goes to S5_RUN. Stage3 has no finished flag.
- **NEXT:**
  - if `tile_idx_o + 1 == count`, go to DONE and leave `tile_idx_o` unchanged;
  - otherwise increment `tile_idx_o` and go to S2_RUN.
- **DONE:** `done_o = 1` for one cycle, then go to IDLE. If `start_i` is high in DONE, treat it as the IDLE start.
- **`vpe_mode_o`:**
  - bits [1:0] = 1 in S2_RUN;
  - bits [3:2] = 1 in S5_RUN;
  - bits [6:4] = 1 in S6_RUN;
  - all other bits 0. `vpe_mode_o` is never 0 inside a RUN state, stall included.
- **`busy_o`:** 1 in every state except IDLE, DONE and ERR.
- **Watchdog:**
  - the counter clears on RUN state entry and counts non-stalled cycles while in S2_RUN, S5_RUN or S6_RUN;
  - reaching `TIMEOUT` with no finish moves the FSM to ERR, sets `err_o = 1` and latches `err_stage_o`;
  - a finish seen in the same cycle the count reaches `TIMEOUT` wins: advance normally, no error.
- **ERR:**
  - all start pulses and `vpe_mode_o` are 0;
  - stays in ERR until `RST_i`, or until `start_i`;
  - `start_i` clears `err_o`/`err_stage_o` and behaves as the IDLE start.
- **`stall_i` = 1:**
  - state, counters and `tile_idx_o` hold;
  - `stage_start_o` is forced to 0, and a pending start pulse is deferred to the first non-stalled cycle;
  - `finished_i` is still sampled, so a finish arriving during a stall advances the state.
- **Reset mid-job:** `RST_i` in any state returns everything to reset values on the next edge. No `done_o` is produced.

## Timing
- All outputs are registered or decoded from state.
- Inputs are sampled on the rising edge of `CLK_i`.
- Start accepted at edge t → S2 pulse in cycle t+1.
- Finish seen in cycle c → next state's pulse in cycle c+1.
- Minimum cycles per tile with finish asserted one cycle after each pulse: 2 (S2) + `S3_LAT` + 2 (S5) + 2 (S6) + 1 (NEXT) = 7 + `S3_LAT`.
- `done_o` follows the last tile's NEXT cycle by one cycle.
- Job latency from the start edge to the `done_o` cycle (inclusive): N·(7 + `S3_LAT`) + 1.

## Test plan
- **Single tile:** `tile_cnt_i = 1`, `S3_LAT = 1`, each finished bit raised one cycle after its pulse → pulses at cycles 1, 3, 4, 6 after the start edge; `done_o` at cycle 9; `busy_o` 0 afterwards.
- **Three tiles with random finish delays of 1–20 cycles:** `tile_idx_o` steps 0→1→2; exactly 3 pulses per stage bit; `done_o` once; `vpe_mode_o` matches the state in every cycle.
- **Zero-count job:** `tile_cnt_i = 0` → `done_o` at cycle 1 after the start edge; no `stage_start_o` bits ever set.
- **Watchdog:** `TIMEOUT = 8`, stage5 finish withheld → ERR 8 cycles after the S5 pulse; `err_o = 1`, `err_stage_o = 2`, `vpe_mode_o = 0`. A following `start_i` clears `err_o` and a new job runs to `done_o`.
- **Stall:** `stall_i` high on the cycle an S6 pulse is due, held for 5 cycles → the pulse appears in the first cycle after the stall drops; `vpe_mode_o[6:4]` stays 1 throughout; watchdog count unchanged across the stall.
- **Reset and busy-start:** `RST_i` asserted mid-S5 of tile 2 → next cycle all outputs 0 and state IDLE. Separately, `start_i` pulsed during S2_RUN → the latched count is unchanged and no restart occurs.

Source files
------------

// File: rtl/tile_stage_scheduler.sv
// Per-lane tile sequencer: walks each tile through stage2 -> stage3 -> stage5 -> stage6,
// owns the lane's VPE mode bits and guards every finish-driven stage with a watchdog.
module tile_stage_scheduler #(
  parameter int CNT_W   = 16,
  parameter int PIPE    = 7,
  parameter int S3_LAT  = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK_i,
  input  logic             RST_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] tile_cnt_i,
  input  logic             stall_i,
  input  logic [2:0]       finished_i,
  output logic [3:0]       stage_start_o,
  output logic [PIPE-1:0]  vpe_mode_o,
  output logic [CNT_W-1:0] tile_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       err_stage_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int S3_W = (S3_LAT > 1) ? $clog2(S3_LAT) : 1;
  localparam logic [WD_W-1:0] WD_LIM  = WD_W'(TIMEOUT);
  localparam logic [S3_W-1:0] S3_LAST = S3_W'(S3_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, S2_RUN, S3_WAIT, S5_RUN, S6_RUN, NEXT, DONE, ERR
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, tile_idx_reg, idx_inc;
  logic [WD_W-1:0]  wd_reg, wd_inc;
  logic [S3_W-1:0]  s3_reg;
  logic             pend_reg, err_reg;
  logic [1:0]       err_stage_reg;
  logic             in_s2, in_s3, in_s5, in_s6, in_run;
  logic             fin_ok, timeout_hit, start_accept;

  always_comb begin
    in_s2  = (state_reg == S2_RUN);
    in_s3  = (state_reg == S3_WAIT);
    in_s5  = (state_reg == S5_RUN);
    in_s6  = (state_reg == S6_RUN);
    in_run = in_s2 | in_s5 | in_s6;
    idx_inc = tile_idx_reg + CNT_W'(1);
    wd_inc  = wd_reg + WD_W'(1);
    // A finish only counts once the stage has actually been started.
    fin_ok = ((in_s2 & finished_i[0]) | (in_s5 & finished_i[1]) | (in_s6 & finished_i[2]))
             & ~pend_reg;
    timeout_hit  = in_run & ~stall_i & ~fin_ok & (wd_inc == WD_LIM);
    start_accept = 1'b0;
    state_next   = state_reg;
    unique case (state_reg)
      IDLE, DONE, ERR: begin
        if (!stall_i) begin
          if (start_i) begin
            start_accept = 1'b1;
            state_next   = (tile_cnt_i == '0) ? DONE : S2_RUN;
          end else if (state_reg == DONE) begin
            state_next = IDLE;
          end
        end
      end
      S2_RUN:  if (fin_ok) state_next = S3_WAIT; else if (timeout_hit) state_next = ERR;
      S3_WAIT: if (!stall_i && s3_reg == S3_LAST) state_next = S5_RUN;
      S5_RUN:  if (fin_ok) state_next = S6_RUN; else if (timeout_hit) state_next = ERR;
      S6_RUN:  if (fin_ok) state_next = NEXT; else if (timeout_hit) state_next = ERR;
      NEXT:    if (!stall_i) state_next = (idx_inc == count_reg) ? DONE : S2_RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      tile_idx_reg  <= '0;
      wd_reg        <= '0;
      s3_reg        <= '0;
      pend_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_stage_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (start_accept) begin
        count_reg     <= tile_cnt_i;
        tile_idx_reg  <= '0;
        err_reg       <= 1'b0;
        err_stage_reg <= 2'd0;
      end else if (state_reg == NEXT && state_next == S2_RUN) begin
        tile_idx_reg <= idx_inc;
      end
      if (timeout_hit) begin
        err_reg       <= 1'b1;
        err_stage_reg <= in_s2 ? 2'd0 : (in_s5 ? 2'd2 : 2'd3);
      end
      // Every state change arms the start pulse and restarts the per-visit counters.
      if (state_next != state_reg) begin
        pend_reg <= 1'b1;
        wd_reg   <= '0;
        s3_reg   <= '0;
      end else if (!stall_i) begin
        pend_reg <= 1'b0;
        if (in_run) wd_reg <= wd_inc;
        if (in_s3)  s3_reg <= s3_reg + S3_W'(1);
      end
    end
  end

  assign stage_start_o = {in_s6, in_s5, in_s3, in_s2} & {4{pend_reg & ~stall_i}};
  assign tile_idx_o    = tile_idx_reg;
  assign busy_o        = in_run | in_s3 | (state_reg == NEXT);
  assign done_o        = (state_reg == DONE);
  assign err_o         = err_reg;
  assign err_stage_o   = err_stage_reg;

  // Slots 0-1 belong to stage2, 2-3 to stage5, 4-6 to stage6.
  for (genvar gi = 0; gi < PIPE; gi++) begin : g_slot
    if (gi < 2) begin : g_s2
      assign vpe_mode_o[gi] = in_s2;
    end else if (gi < 4) begin : g_s5
      assign vpe_mode_o[gi] = in_s5;
    end else if (gi < 7) begin : g_s6
      assign vpe_mode_o[gi] = in_s6;
    end else begin : g_none
      assign vpe_mode_o[gi] = 1'b0;
    end
  end

endmodule
